// File: rtl/serial_word_receiver_pkg.sv
// Shared definitions for the serial word receiver slice.
//   state_t : receiver FSM states (IDLE waits for a framed bit, SHIFT collects bits)
//   DIR_MSB / DIR_LSB : values of the DIR input selecting bit order
package serial_word_receiver_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic DIR_MSB = 1'b1;
    localparam logic DIR_LSB = 1'b0;

endpackage

// File: rtl/serial_word_shifter.sv
// WIDTH-bit bidirectional shift register with a clear.
//   clk, rst : clock, synchronous active-high reset
//   clr      : start from an empty register (combined with en, the first bit lands on an empty word)
//   en       : shift one bit in this cycle
//   dir      : DIR_MSB shifts left (first bit ends at MSB), DIR_LSB shifts right (first bit ends at LSB)
//   sin      : serial bit to shift in
//   q        : current register contents
//   nxt      : value q takes on the next edge (lets the parent capture the completed word without delay)
module serial_word_shifter
    import serial_word_receiver_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             dir,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nxt
);

    logic [WIDTH-1:0] base;

    always_comb begin
        base = clr ? '0 : q;
        nxt  = base;
        if (en) begin
            if (dir == DIR_MSB) begin
                nxt = {base[WIDTH-2:0], sin};
            end else begin
                nxt = {sin, base[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-word receiver: assembles WIDTH framed serial bits into a word and
// offers it through a one-entry valid/ready holding register.
//   CLK, RST         : clock, synchronous active-high reset
//   SIN, SVALID      : serial bit and its strobe
//   FRAME            : marks the strobed bit as the first bit of a word
//   DIR              : bit order (1 MSB-first, 0 LSB-first), sampled on the framed bit only
//   DOUT, DVALID     : held word and its valid flag
//   DREADY           : consumer accepts DOUT when DVALID && DREADY
//   BUSY             : a partial word is being collected
//   OVERRUN          : sticky, a completed word was dropped because the holding register was full
//   ALIGNERR         : sticky, a partial word was discarded by an early FRAME
//   CLR_ERR          : clears the sticky flags (a coincident set event wins)
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNTW  = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIN,
    input  logic             SVALID,
    input  logic             FRAME,
    input  logic             DIR,
    output logic [WIDTH-1:0] DOUT,
    output logic             DVALID,
    input  logic             DREADY,
    output logic             BUSY,
    output logic             OVERRUN,
    output logic             ALIGNERR,
    input  logic             CLR_ERR
);

    state_t           state, state_n;
    logic [CNTW-1:0]  cnt, cnt_n;
    logic             dir_q;
    logic             dir_eff;
    logic             take_first;
    logic             shift_en;
    logic             complete;
    logic             set_align;
    logic             set_ovr;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] word;

    // The framed bit must use the live DIR, later bits the latched one.
    assign take_first = SVALID & FRAME;
    assign dir_eff    = take_first ? DIR : dir_q;
    assign BUSY       = (state == ST_SHIFT);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shift_en  = 1'b0;
        complete  = 1'b0;
        set_align = 1'b0;
        if (SVALID) begin
            if (FRAME) begin
                set_align = (state == ST_SHIFT);
                shift_en  = 1'b1;
                cnt_n     = CNTW'(1);
                state_n   = ST_SHIFT;
            end else if (state == ST_SHIFT) begin
                shift_en = 1'b1;
                if (cnt == CNTW'(WIDTH - 1)) begin
                    complete = 1'b1;
                    cnt_n    = '0;
                    state_n  = ST_IDLE;
                end else begin
                    cnt_n = cnt + CNTW'(1);
                end
            end
        end
    end

    assign set_ovr = complete & DVALID & ~DREADY;

    serial_word_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk (CLK),
        .rst (RST),
        .clr (take_first),
        .en  (shift_en),
        .dir (dir_eff),
        .sin (SIN),
        .q   (sh_q),
        .nxt (word)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            dir_q    <= DIR_LSB;
            DOUT     <= '0;
            DVALID   <= 1'b0;
            OVERRUN  <= 1'b0;
            ALIGNERR <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (take_first) begin
                dir_q <= DIR;
            end
            if (complete) begin
                if (!DVALID || DREADY) begin
                    DOUT   <= word;
                    DVALID <= 1'b1;
                end
            end else if (DVALID && DREADY) begin
                DVALID <= 1'b0;
            end
            OVERRUN  <= (OVERRUN  & ~CLR_ERR) | set_ovr;
            ALIGNERR <= (ALIGNERR & ~CLR_ERR) | set_align;
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver (WIDTH=4): directed scenarios
// followed by random traffic, all checked against a bit-queue reference model.
module tb_serial_word_receiver;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST, SIN, SVALID, FRAME, DIR, DREADY, CLR_ERR;
    logic [W-1:0] DOUT;
    logic         DVALID, BUSY, OVERRUN, ALIGNERR;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    bit           mbits[$];
    logic         m_active, m_dir, m_dvalid, m_ovr, m_aln;
    logic [W-1:0] m_dout;

    always #5 CLK = ~CLK;

    serial_word_receiver #(
        .WIDTH (W),
        .CNTW  (3)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SIN      (SIN),
        .SVALID   (SVALID),
        .FRAME    (FRAME),
        .DIR      (DIR),
        .DOUT     (DOUT),
        .DVALID   (DVALID),
        .DREADY   (DREADY),
        .BUSY     (BUSY),
        .OVERRUN  (OVERRUN),
        .ALIGNERR (ALIGNERR),
        .CLR_ERR  (CLR_ERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge, written from the word-level rules.
    task automatic model(input logic sin, sv, fr, dr, dy, ce, rs);
        logic         complete, set_o, set_a, newv;
        logic [W-1:0] w;
        complete = 1'b0;
        set_o    = 1'b0;
        set_a    = 1'b0;
        w        = '0;
        if (rs) begin
            mbits.delete();
            m_active = 1'b0;
            m_dir    = 1'b0;
            m_dout   = '0;
            m_dvalid = 1'b0;
            m_ovr    = 1'b0;
            m_aln    = 1'b0;
            return;
        end
        if (sv) begin
            if (fr) begin
                if (m_active) set_a = 1'b1;
                mbits.delete();
                mbits.push_back(sin);
                m_dir    = dr;
                m_active = 1'b1;
            end else if (m_active) begin
                mbits.push_back(sin);
                if (mbits.size() == W) begin
                    // k-th received bit goes to position W-1-k (MSB-first) or k (LSB-first)
                    for (int k = 0; k < W; k++) begin
                        if (mbits[k]) w[m_dir ? (W - 1 - k) : k] = 1'b1;
                    end
                    complete = 1'b1;
                    m_active = 1'b0;
                    mbits.delete();
                end
            end
        end
        newv = m_dvalid;
        if (complete) begin
            if (!m_dvalid || dy) begin
                m_dout = w;
                newv   = 1'b1;
            end else begin
                set_o = 1'b1;
            end
        end else if (m_dvalid && dy) begin
            newv = 1'b0;
        end
        m_dvalid = newv;
        m_ovr    = (m_ovr && !ce) || set_o;
        m_aln    = (m_aln && !ce) || set_a;
    endtask

    task automatic step(input logic sin, sv, fr, dr, dy, ce, rs);
        @(negedge CLK);
        SIN = sin; SVALID = sv; FRAME = fr; DIR = dr; DREADY = dy; CLR_ERR = ce; RST = rs;
        @(posedge CLK);
        model(sin, sv, fr, dr, dy, ce, rs);
        #1;
        chk("dout",     DOUT,     m_dout);
        chk("dvalid",   DVALID,   m_dvalid);
        chk("busy",     BUSY,     m_active);
        chk("overrun",  OVERRUN,  m_ovr);
        chk("alignerr", ALIGNERR, m_aln);
    endtask

    // Non-framed bits carry the opposite DIR to show it is ignored mid-word.
    task automatic send_word(input logic [W-1:0] w, input logic d, input logic dy, input bit gaps);
        logic b;
        for (int i = 0; i < W; i++) begin
            b = d ? w[W - 1 - i] : w[i];
            step(b, 1'b1, (i == 0), (i == 0) ? d : ~d, dy, 1'b0, 1'b0);
            if (gaps && i < W - 1) begin
                step(1'b0, 1'b0, 1'b0, ~d, dy, 1'b0, 1'b0);
                step(1'b1, 1'b0, 1'b1, d, dy, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        RST = 1'b1; SIN = 1'b0; SVALID = 1'b0; FRAME = 1'b0; DIR = 1'b0; DREADY = 1'b0; CLR_ERR = 1'b0;
        mbits.delete();
        m_active = 1'b0; m_dir = 1'b0; m_dout = '0; m_dvalid = 1'b0; m_ovr = 1'b0; m_aln = 1'b0;

        // reset
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("rst_dout", DOUT, 4'h0);
        chk("rst_dvalid", DVALID, 1'b0);

        // T1 MSB-first
        send_word(4'b1011, 1'b1, 1'b0, 1'b0);
        chk("t1_dout", DOUT, 4'b1011);
        chk("t1_dvalid", DVALID, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t1_drain", DVALID, 1'b0);

        // T2 LSB-first with idle gaps
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_busy_first", BUSY, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_busy_mid", BUSY, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_dout", DOUT, 4'b0001);
        chk("t2_busy_end", BUSY, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // T3 overrun, then drain and clear together
        send_word(4'hA, 1'b1, 1'b0, 1'b1);
        send_word(4'h5, 1'b0, 1'b0, 1'b0);
        chk("t3_dout", DOUT, 4'hA);
        chk("t3_overrun", OVERRUN, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_dvalid", DVALID, 1'b0);
        chk("t3_cleared", OVERRUN, 1'b0);

        // T4 realign by early FRAME
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word(4'b0110, 1'b1, 1'b1, 1'b0);
        chk("t4_alignerr", ALIGNERR, 1'b1);
        chk("t4_dout", DOUT, 4'b0110);
        // set event coincident with CLR_ERR keeps the flag
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4_set_wins", ALIGNERR, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4_clr", ALIGNERR, 1'b0);
        send_word(4'h0, 1'b1, 1'b1, 1'b0);

        // T5 back-to-back with DREADY held
        send_word(4'h3, 1'b0, 1'b1, 1'b0);
        chk("t5_first", DOUT, 4'h3);
        send_word(4'hC, 1'b1, 1'b1, 1'b0);
        chk("t5_second", DOUT, 4'hC);
        chk("t5_dvalid", DVALID, 1'b1);

        // T6 reset mid-word
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_dout", DOUT, 4'h0);
        chk("t6_busy", BUSY, 1'b0);
        for (int i = 0; i < W; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t6_ignored", DVALID, 1'b0);
        send_word(4'h9, 1'b1, 1'b0, 1'b0);
        chk("t6_word", DOUT, 4'h9);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
